// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-port memory between the instruction-fetch
// and load/store ports, running one fixed-latency transaction at a time.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  input  logic        ls_req_valid,
  input  logic        ls_req_we,
  input  logic [31:0] ls_req_addr,
  input  logic [31:0] ls_req_wdata,
  output logic        ls_req_ready,
  output logic        ls_rsp_valid,
  output logic [31:0] ls_rsp_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_ls_q, last_ls_d;
  logic        owner_ls_q, owner_ls_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic        if_rsp_valid_q, if_rsp_valid_d;
  logic        ls_rsp_valid_q, ls_rsp_valid_d;
  logic        if_win, ls_win;

  // On a tie the port that did not win last time gets the grant.
  assign if_win = if_req_valid && (!ls_req_valid || last_ls_q);
  assign ls_win = ls_req_valid && !if_win;

  assign if_req_ready = (state_q == IDLE) && if_win;
  assign ls_req_ready = (state_q == IDLE) && ls_win;

  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign if_rsp_valid = if_rsp_valid_q;
  assign ls_rsp_valid = ls_rsp_valid_q;
  assign if_rsp_data  = rsp_data_q;
  assign ls_rsp_rdata = rsp_data_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_ls_d      = last_ls_q;
    owner_ls_d     = owner_ls_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rsp_data_d     = rsp_data_q;
    mem_en_d       = mem_en_q;
    mem_we_d       = mem_we_q;
    if_rsp_valid_d = 1'b0;
    ls_rsp_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_win) begin
          owner_ls_d = 1'b0;
          last_ls_d  = 1'b0;
          we_d       = 1'b0;
          addr_d     = if_req_addr & ~32'h3;
          wdata_d    = 32'd0;
          cnt_d      = CNT_INIT;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          state_d    = ACCESS;
        end else if (ls_win) begin
          owner_ls_d = 1'b1;
          last_ls_d  = 1'b1;
          we_d       = ls_req_we;
          addr_d     = ls_req_addr & ~32'h3;
          wdata_d    = ls_req_wdata;
          cnt_d      = CNT_INIT;
          mem_en_d   = 1'b1;
          mem_we_d   = ls_req_we;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          // Stores acknowledge with zero data rather than whatever the macro drives.
          rsp_data_d     = we_q ? 32'd0 : mem_rdata;
          mem_en_d       = 1'b0;
          mem_we_d       = 1'b0;
          if_rsp_valid_d = !owner_ls_q;
          ls_rsp_valid_d = owner_ls_q;
          state_d        = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      last_ls_q      <= 1'b1;
      owner_ls_q     <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= 32'd0;
      wdata_q        <= 32'd0;
      rsp_data_q     <= 32'd0;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      if_rsp_valid_q <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_ls_q      <= last_ls_d;
      owner_ls_q     <= owner_ls_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rsp_data_q     <= rsp_data_d;
      mem_en_q       <= mem_en_d;
      mem_we_q       <= mem_we_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      ls_rsp_valid_q <= ls_rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table for single transactions,
// hand sequences for arbitration, back-pressure and reset corners, response scoreboard.
module tb_mem_port_arbiter;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        ls_req_valid;
  logic        ls_req_we;
  logic [31:0] ls_req_addr;
  logic [31:0] ls_req_wdata;
  logic        ls_req_ready;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        use_seq;
  logic [31:0] seq_val;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic        is_ls;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        is_ls;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rsp;
  } vec_t;
  vec_t vecs[6];

  mem_port_arbiter #(.MEM_LAT(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .if_req_valid (if_req_valid),
    .if_req_addr  (if_req_addr),
    .if_req_ready (if_req_ready),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .ls_req_valid (ls_req_valid),
    .ls_req_we    (ls_req_we),
    .ls_req_addr  (ls_req_addr),
    .ls_req_wdata (ls_req_wdata),
    .ls_req_ready (ls_req_ready),
    .ls_rsp_valid (ls_rsp_valid),
    .ls_rsp_rdata (ls_rsp_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  always_comb mem_rdata = use_seq ? seq_val : mem_model(mem_addr);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one request, waits (bounded) for its accept and queues the expected response.
  task automatic applyStimulus(input logic is_ls, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_data,
                               output int acc_cyc);
    @(negedge clk);
    if (is_ls) begin
      ls_req_valid = 1'b1;
      ls_req_we    = we;
      ls_req_addr  = addr;
      ls_req_wdata = wdata;
    end else begin
      if_req_valid = 1'b1;
      if_req_addr  = addr;
    end
    acc_cyc = -1;
    for (int t = 0; t < 40 && acc_cyc < 0; t++) begin
      #1;
      if (is_ls ? ls_req_ready : if_req_ready) acc_cyc = cyc + 1;
      else @(negedge clk);
    end
    if (acc_cyc < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: request never accepted (is_ls=%0d)", is_ls);
    end else begin
      sb.push_back('{is_ls, exp_data, acc_cyc + LAT});
    end
    @(posedge clk);
    #1;
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
  endtask

  // Scoreboard: every response pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && (if_rsp_valid || ls_rsp_valid)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: if_rsp_valid=%0d ls_rsp_valid=%0d with nothing pending",
                 if_rsp_valid, ls_rsp_valid);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("rsp_port", {30'd0, if_rsp_valid, ls_rsp_valid}, {30'd0, !e.is_ls, e.is_ls});
        checkOutput("rsp_data", e.is_ls ? ls_rsp_rdata : if_rsp_data, e.data);
        checkOutput("rsp_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic check_access(input string tag, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata);
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      checkOutput({tag, "_mem_en"}, {31'd0, mem_en}, 32'd1);
      checkOutput({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, we});
      checkOutput({tag, "_mem_addr"}, mem_addr, addr);
      checkOutput({tag, "_mem_wdata"}, mem_wdata, wdata);
    end
    @(negedge clk);
    checkOutput({tag, "_mem_en_resp"}, {31'd0, mem_en}, 32'd0);
    checkOutput({tag, "_mem_we_resp"}, {31'd0, mem_we}, 32'd0);
  endtask

  initial begin
    int acc, acc2, prev, rel_cyc;
    logic got;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,          32'h0000_0044, 1'b0, 32'h0,          32'hC0DE_0044};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_2007, 32'h5555_5555, 32'h0000_2004, 1'b0, 32'h5555_5555, 32'hC0DE_2004};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,          32'hFFFF_FFFC, 1'b0, 32'h0,          32'h3F21_FFFC};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0102, 32'h1234_5678, 32'h0000_0100, 1'b1, 32'h1234_5678, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h8000_000A, 32'h0,          32'h8000_0008, 1'b0, 32'h0,          32'h40DE_0008};

    reset = 1'b0;
    if_req_valid = 1'b0; if_req_addr = '0;
    ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_addr = '0; ls_req_wdata = '0;
    use_seq = 1'b0; seq_val = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mem_en", {31'd0, mem_en}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_rsp_valid", {30'd0, if_rsp_valid, ls_rsp_valid}, 32'd0);
    checkOutput("rst_if_rsp_data", if_rsp_data, 32'd0);
    checkOutput("rst_ls_rsp_rdata", ls_rsp_rdata, 32'd0);
    checkOutput("rst_ready_idle", {30'd0, if_req_ready, ls_req_ready}, 32'd0);
    reset = 1'b1;
    rel_cyc = cyc;

    // IF fetch straight out of reset, unaligned address.
    use_seq = 1'b1;
    seq_val = 32'h0000_0093;
    applyStimulus(1'b0, 1'b0, 32'h0000_0013, 32'h0, 32'h0000_0093, acc);
    checkOutput("if_first_cycle_accept", 32'(acc), 32'(rel_cyc + 1));
    check_access("if0", 1'b0, 32'h0000_0010, 32'h0);
    @(negedge clk);
    use_seq = 1'b0;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].is_ls, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rsp, acc);
      check_access($sformatf("v%0d", i), vecs[i].exp_we, vecs[i].exp_addr, vecs[i].exp_wdata);
      @(negedge clk);
    end

    // Load with read data changing every ACCESS cycle: only the last one is captured.
    use_seq = 1'b1;
    seq_val = 32'h0000_0FFF;
    applyStimulus(1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'h0000_1000 + LAT, acc);
    for (int k = 1; k <= LAT; k++) begin
      seq_val = 32'h0000_1000 + k;
      @(posedge clk);
      #1;
    end
    seq_val = 32'h0000_2000;
    repeat (3) @(negedge clk);
    use_seq = 1'b0;

    // Fresh reset, then both ports valid continuously: IF, LS, IF, LS.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0040;
    ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'h0000_0080;
    prev = 0;
    for (int n = 0; n < 4; n++) begin
      got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
        #1;
        if (if_req_ready || ls_req_ready) got = 1'b1;
        else @(negedge clk);
      end
      if (!got) begin
        checks++;
        errors++;
        $display("[TB] FAIL rr_timeout: no grant for tie %0d", n);
      end else begin
        acc = cyc + 1;
        checkOutput($sformatf("rr_grant%0d", n), {30'd0, if_req_ready, ls_req_ready},
                    (n % 2 == 0) ? 32'd2 : 32'd1);
        if (n > 0) checkOutput($sformatf("rr_spacing%0d", n), 32'(acc - prev), 32'(LAT + 2));
        prev = acc;
        sb.push_back('{(n % 2 == 1), mem_model((n % 2 == 1) ? 32'h80 : 32'h40), acc + LAT});
      end
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    repeat (LAT + 3) @(negedge clk);

    // IF arrives while LS owns the memory: held off until the IDLE after LS's RESP.
    applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'h0, mem_model(32'h200), acc);
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0000_0204;
    for (int k = 0; k < LAT + 1; k++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("if_blocked%0d", k), {31'd0, if_req_ready}, 32'd0);
    end
    @(negedge clk);
    #1;
    checkOutput("if_after_resp_ready", {31'd0, if_req_ready}, 32'd1);
    acc2 = cyc + 1;
    checkOutput("if_after_resp_accept", 32'(acc2), 32'(acc + LAT + 2));
    sb.push_back('{1'b0, mem_model(32'h204), acc2 + LAT});
    @(posedge clk);
    #1;
    if_req_valid = 1'b0;
    repeat (LAT + 3) @(negedge clk);

    // Reset in the 2nd ACCESS cycle of an IF fetch: dropped, and last grant back to LS.
    applyStimulus(1'b0, 1'b0, 32'h0000_0400, 32'h0, mem_model(32'h400), acc);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midrst_mem_en", {31'd0, mem_en}, 32'd0);
    checkOutput("midrst_mem_we", {31'd0, mem_we}, 32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0500;
    ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'h0000_0600;
    #1;
    checkOutput("post_rst_tie", {30'd0, if_req_ready, ls_req_ready}, 32'd2);
    sb.push_back('{1'b0, mem_model(32'h500), cyc + 1 + LAT});
    @(posedge clk);
    #1;
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    repeat (LAT + 4) @(negedge clk);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between two requesters: the instruction-fetch port (IF) and the load/store port (LS).
- Handles one transaction at a time, using round-robin arbitration, a fixed-latency memory access and a one-cycle response pulse back to the winning requester.
- Sits between the fetch/LSU front ends and the unified memory macro in the multi-cycle core variant.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from mem_en assertion to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req_valid  in  1  IF request present.
- if_req_addr  in  32  IF byte address.
- if_req_ready  out  1  IF request accepted this cycle.
- if_rsp_valid  out  1  one-cycle IF response pulse.
- if_rsp_data  out  32  fetched word; valid while if_rsp_valid=1.
- ls_req_valid  in  1  LS request present.
- ls_req_we  in  1  1 = store, 0 = load.
- ls_req_addr  in  32  LS byte address.
- ls_req_wdata  in  32  store data.
- ls_req_ready  out  1  LS request accepted this cycle.
- ls_rsp_valid  out  1  one-cycle LS response pulse (load data or store ack).
- ls_rsp_rdata  out  32  load data; 0 for store acks.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  word-aligned address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  memory read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0, last_grant=LS.
  - All outputs 0, except req_ready, which follows the IDLE rules below.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready is combinational and asserted only to the arbitration winner; accept = valid && ready.
  - Only one requester valid: that requester wins.
  - Both valid: the requester not in last_grant wins, so IF wins the first tie after reset.
  - On accept, register owner, we (IF is always 0), addr with bits [1:0] forced to 00, and wdata (IF uses 0).
  - On accept, set last_grant=owner, cnt=MEM_LAT-1, and go to ACCESS.
  - No valid: stay in IDLE.
- ACCESS:
  - mem_en=1; mem_we/mem_addr/mem_wdata come from the registered values, held stable for all MEM_LAT cycles.
  - cnt decrements each cycle.
  - When cnt==0: capture mem_rdata (or 0 if we=1) into the response register, then go to RESP.
- RESP:
  - Owner's rsp_valid=1 for exactly one cycle with the captured data; the other port's rsp_valid stays 0.
  - Next state is IDLE.
  - rsp_data holds its value until the next capture.
- Timing:
  - Latency from the accept edge to rsp_valid is MEM_LAT+1 cycles.
  - Peak throughput is one transaction per MEM_LAT+2 cycles.
- req_ready is 0 in ACCESS and RESP. Requests arriving there wait, and requesters must hold valid/addr/data stable until ready.
- No new request can be accepted in the RESP cycle; the next accept is in the following IDLE cycle.
- mem_en/mem_we are 0 outside ACCESS.
- Reset asserted mid-ACCESS or mid-RESP:
  - Transaction is dropped; no rsp pulse.
  - mem_en/mem_we drop immediately (asynchronously).
  - last_grant returns to LS.
- Unknown or illegal state encodings recover to IDLE.

Test Plan:
- Reset release, IF only, addr 0x0000_0013, mem returns 0x0000_0093, MEM_LAT=1:
  - if_req_ready=1 in the first cycle.
  - mem_addr=0x0000_0010 with mem_en high for 1 cycle.
  - if_rsp_valid pulses 2 cycles after accept with data 0x0000_0093.
- Both valid continuously after reset:
  - Grants alternate IF, LS, IF, LS.
  - A new accept occurs every MEM_LAT+2 cycles.
  - No response goes to the wrong port.
- LS store, addr 0x100, wdata 0xDEADBEEF, MEM_LAT=3:
  - mem_en=mem_we=1 for exactly 3 cycles with stable addr/wdata.
  - ls_rsp_valid pulses once with ls_rsp_rdata=0.
- LS load with MEM_LAT=4, mem_rdata changing each cycle: ls_rsp_rdata equals the value sampled on the 4th ACCESS cycle.
- reset driven low during the 2nd ACCESS cycle:
  - mem_en goes 0 immediately.
  - No rsp_valid pulse after release.
  - The next tie is granted to IF.
- IF raises valid during an LS ACCESS: if_req_ready stays 0 until IDLE, then IF is accepted in the cycle after LS's RESP.
